equiv_check_sequencer: RTL
==========================

# equiv_check_sequencer

On-chip stimulus sequencer and comparator for equivalence-checking a generated two-input clocked cell against its source implementation. It drives identical pseudo-random `a`/`b` stimulus into both units and waits a fixed settle window per vector. It then compares the two outputs and reports pass/fail, the mismatch count and the first failing vector. It replaces the free-running bench stimulus loop, so the same check runs in simulation, emulation or silicon.

## Interface
- `NUM_VECTORS`, 16: vectors applied per run; legal range 1..256.
- `WARMUP_CYCLES`, 100: idle cycles after start before the first vector; legal range ≥1.
- `SETTLE_CYCLES`, 25: cycles each vector is held before comparison; legal range ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR load value; a value of 0 is replaced by 16'hACE1.
- `STOP_ON_FAIL`, 1: 1 ends the run at the first mismatch; 0 runs all vectors.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request; sampled only in IDLE or DONE.
- `dut_out` in 1: output of the unit under test.
- `ref_out` in 1: output of the source (golden) unit.
- `a_out` out 1: stimulus to the `a_in` port of both units; registered.
- `b_out` out 1: stimulus to the `b_in` port of both units; registered.
- `busy` out 1: high in WARMUP, SETTLE and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `mismatch_count`==0.
- `fail` out 1: high in DONE when `mismatch_count`!=0.
- `mismatch_count` out 8: number of mismatching vectors; saturates at 255.
- `vector_index` out 8: index of the vector currently applied, or the last one applied.
- `fail_vector` out 8: index of the first mismatching vector; valid when `fail`=1.
- `fail_a`, `fail_b` out 1 each: stimulus of the first mismatching vector.

## Operation
- States: IDLE, WARMUP, SETTLE, CHECK, DONE.
- Reset state:
  - state=IDLE; LFSR=seed.
  - `a_out`, `b_out`, `busy`, `done`, `pass`, `fail` = 0.
  - `mismatch_count`, `vector_index`, `fail_vector`, `fail_a`, `fail_b` = 0.
- LFSR: 16-bit Galois, right-shift. Next value = (L>>1) ^ (L[0] ? 16'hB400 : 0).
- Vector k stimulus: `a_out`=L[0], `b_out`=L[1], where L is the LFSR after k steps from the seed. Vector 0 uses the seed itself.
- IDLE or DONE with `start`=1:
  - Clear all result outputs and `vector_index`; reload LFSR=seed.
  - `a_out`=`b_out`=0; go to WARMUP.
- WARMUP: hold for exactly WARMUP_CYCLES cycles. On exit, load `a_out`/`b_out` from the LFSR and go to SETTLE.
- SETTLE: hold stimulus for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (one cycle): compare `dut_out` against `ref_out`, sampled at the edge leaving CHECK.
  - On mismatch: `mismatch_count`+1 (saturating). If it is the first mismatch, capture `fail_vector`=`vector_index` and `fail_a`/`fail_b`=current stimulus.
  - Mismatch and STOP_ON_FAIL=1: go to DONE.
  - Else if `vector_index`==NUM_VECTORS-1: go to DONE.
  - Else: step LFSR, `vector_index`+1, drive the new `a_out`/`b_out`, go to SETTLE.
- DONE: all outputs hold; `a_out`/`b_out` keep the last vector.
- `start` in WARMUP, SETTLE or CHECK is ignored; there is no abort except `reset_n`.
- `reset_n` low mid-run forces the reset state immediately, asynchronously. No partial results are retained.
- `dut_out` and `ref_out` are treated as synchronous to `clock`. Any settle margin is provided by SETTLE_CYCLES, not by synchronizers.

## Timing
- `start` sampled high at edge E0: `busy`=1 after E0.
- First vector appears on `a_out`/`b_out` after edge E0+WARMUP_CYCLES.
- Each vector takes SETTLE_CYCLES+1 cycles, comparison included.
- Full passing run: `done`=1 after edge E0+WARMUP_CYCLES+NUM_VECTORS·(SETTLE_CYCLES+1). With defaults this is E0+516.
- Early stop at vector k: `done`=1 after edge E0+WARMUP_CYCLES+(k+1)·(SETTLE_CYCLES+1).
- `pass`, `fail` and `done` change on the same edge; `pass` and `fail` are never both 1.

## Test plan
- Reset, then `dut_out` tied to `ref_out` with AND behaviour, `start` pulse:
  - Vector 0: `a_out`=1, `b_out`=0.
  - Vector 1 (LFSR 16'hE270): `a_out`=0, `b_out`=0.
  - `done`=`pass`=1 at E0+516; `mismatch_count`=0; `vector_index`=15.
- Force `dut_out`=~`ref_out` from vector 3 on, STOP_ON_FAIL=1: `done`=`fail`=1 at E0+100+4·26=E0+204; `fail_vector`=3; `mismatch_count`=1.
- Same fault with STOP_ON_FAIL=0: run reaches `vector_index`=15; `mismatch_count`=13; `fail_vector`=3.
- `start` pulsed during SETTLE of vector 2: no effect; finish time unchanged. A second `start` in DONE clears results and repeats the identical vector sequence.
- `reset_n` low for one cycle during vector 5: all outputs 0 immediately; state IDLE; no run until the next `start`.
- LFSR_SEED=0: behaves as 16'hACE1; vector 0 is `a_out`=1, `b_out`=0.

Source files
------------

// File: rtl/equiv_check_sequencer.sv
// Stimulus sequencer and comparator for equivalence-checking a generated two-input cell.
// Drives LFSR-derived a/b into both units, waits a settle window, compares and records results.
`timescale 1ns/1ps
module equiv_check_sequencer #(
  parameter int          NUM_VECTORS   = 16,
  parameter int          WARMUP_CYCLES = 100,
  parameter int          SETTLE_CYCLES = 25,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter bit          STOP_ON_FAIL  = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dut_out,
  input  logic       ref_out,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [7:0] mismatch_count,
  output logic [7:0] vector_index,
  output logic [7:0] fail_vector,
  output logic       fail_a,
  output logic       fail_b
);

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam int          CNT_MAX  = (WARMUP_CYCLES > SETTLE_CYCLES) ? WARMUP_CYCLES : SETTLE_CYCLES;
  localparam int          CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WARM_LAST   = CW'(WARMUP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  LAST_VEC = 8'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [CW-1:0] r_cnt;

  logic [15:0] w_lfsr_next;
  logic        w_mismatch;
  logic [7:0]  w_mc_inc;
  logic        w_stop;
  logic        w_any_fail;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_mismatch  = dut_out ^ ref_out;
  assign w_mc_inc    = (mismatch_count == 8'hFF) ? mismatch_count : mismatch_count + 8'd1;
  assign w_stop      = (w_mismatch && STOP_ON_FAIL) || (vector_index == LAST_VEC);
  assign w_any_fail  = w_mismatch || (mismatch_count != 8'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_lfsr         <= SEED;
      r_cnt          <= '0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      mismatch_count <= 8'd0;
      vector_index   <= 8'd0;
      fail_vector    <= 8'd0;
      fail_a         <= 1'b0;
      fail_b         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state        <= S_WARMUP;
            r_lfsr         <= SEED;
            r_cnt          <= '0;
            a_out          <= 1'b0;
            b_out          <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            mismatch_count <= 8'd0;
            vector_index   <= 8'd0;
            fail_vector    <= 8'd0;
            fail_a         <= 1'b0;
            fail_b         <= 1'b0;
          end
        end
        S_WARMUP: begin
          if (r_cnt == WARM_LAST) begin
            r_cnt   <= '0;
            a_out   <= r_lfsr[0];
            b_out   <= r_lfsr[1];
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            mismatch_count <= w_mc_inc;
            if (mismatch_count == 8'd0) begin
              fail_vector <= vector_index;
              fail_a      <= a_out;
              fail_b      <= b_out;
            end
          end
          if (w_stop) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !w_any_fail;
            fail    <= w_any_fail;
          end else begin
            r_lfsr       <= w_lfsr_next;
            vector_index <= vector_index + 8'd1;
            a_out        <= w_lfsr_next[0];
            b_out        <= w_lfsr_next[1];
            r_state      <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
